// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Holds the memory-stage FSM state type and the vector/word geometry.
package cpu_pkg;

  localparam int VEC_LANES = 8;
  localparam int WORD_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    S_RD,
    V_RD,
    V_WR,
    DONE
  } mem_state_t;

endpackage

// File: rtl/memory_access_unit.sv
// Memory stage: scalar and multi-beat vector loads/stores over one
// 16-bit synchronous data port, stalling upstream until results land.
//
// Ports:
//   clk, reset             clock, async active-high reset
//   mem_read, mem_write    load / store request from EX/MEM
//   vector_op              1 = vector (LANES x 16), 0 = scalar
//   address                base word address
//   store_data             scalar store data
//   vector_store_data      vector store data, lane k at [16k+15:16k]
//   mem_addr/we/re/wdata   data-memory port (combinational)
//   mem_rdata              read data, one cycle after mem_re
//   data_from_memory       last scalar load result
//   vector_data_from_memory last vector load result
//   stall                  freeze upstream, bubble into MEM/WB
module memory_access_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LANES  = VEC_LANES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic                     vector_op,
  input  logic [ADDR_W-1:0]        address,
  input  logic [WORD_W-1:0]        store_data,
  input  logic [WORD_W*LANES-1:0]  vector_store_data,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_we,
  output logic                     mem_re,
  output logic [WORD_W-1:0]        mem_wdata,
  input  logic [WORD_W-1:0]        mem_rdata,
  output logic [WORD_W-1:0]        data_from_memory,
  output logic [WORD_W*LANES-1:0]  vector_data_from_memory,
  output logic                     stall
);

  localparam int BW = $clog2(LANES + 1);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [BW-1:0] B_ONE  = BW'(1);
  localparam logic [BW-1:0] B_LAST = BW'(LANES);
  localparam logic [BW-1:0] B_LM1  = BW'(LANES - 1);

  mem_state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;

  logic [WORD_W-1:0] data_q;
  logic [WORD_W-1:0] rd_lane [LANES];
  logic [WORD_W-1:0] st_lane [LANES];

  logic              s_cap;
  logic              v_cap;
  logic [LW-1:0]     cap_idx;
  logic [LW-1:0]     wr_idx;
  logic [ADDR_W-1:0] beat_addr;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign st_lane[k] =
      vector_store_data[WORD_W*k +: WORD_W];
    assign vector_data_from_memory[WORD_W*k +: WORD_W] =
      rd_lane[k];
  end

  // Read data returning now belongs to the read issued last beat.
  assign cap_idx   = LW'(beat_q - B_ONE);
  assign wr_idx    = LW'(beat_q);
  assign beat_addr = address + ADDR_W'(beat_q);

  assign data_from_memory = data_q;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = '0;
    stall     = 1'b0;
    s_cap     = 1'b0;
    v_cap     = 1'b0;
    // Held-high requests must not leak strobes while in reset.
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            mem_read: begin
              mem_re   = 1'b1;
              mem_addr = address;
              stall    = 1'b1;
              if (vector_op) begin
                beat_d  = B_ONE;
                state_d = V_RD;
              end else begin
                state_d = S_RD;
              end
            end
            mem_write && !mem_read: begin
              mem_we   = 1'b1;
              mem_addr = address;
              if (vector_op) begin
                mem_wdata = st_lane[0];
                stall     = 1'b1;
                beat_d    = B_ONE;
                state_d   = V_WR;
              end else begin
                mem_wdata = store_data;
              end
            end
            default: ;
          endcase
        end
        S_RD: begin
          s_cap   = 1'b1;
          stall   = 1'b1;
          state_d = DONE;
        end
        V_RD: begin
          v_cap = 1'b1;
          stall = 1'b1;
          if (beat_q < B_LAST) begin
            mem_re   = 1'b1;
            mem_addr = beat_addr;
            beat_d   = beat_q + B_ONE;
          end else begin
            state_d = DONE;
          end
        end
        V_WR: begin
          mem_we    = 1'b1;
          mem_addr  = beat_addr;
          mem_wdata = st_lane[wr_idx];
          if (beat_q < B_LM1) begin
            stall  = 1'b1;
            beat_d = beat_q + B_ONE;
          end else begin
            beat_d  = '0;
            state_d = IDLE;
          end
        end
        DONE: begin
          beat_d  = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      data_q  <= '0;
      for (int k = 0; k < LANES; k++) begin
        rd_lane[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (s_cap) begin
        data_q <= mem_rdata;
      end
      if (v_cap) begin
        rd_lane[cap_idx] <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit.
// Scoreboard queues hold expected strobe addresses, write data, results.
module tb_memory_access_unit;
  import cpu_pkg::*;

  localparam int AW = 16;
  localparam int LN = 8;
  localparam int VW = 16 * LN;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_read;
  logic          mem_write;
  logic          vector_op;
  logic [AW-1:0] address;
  logic [15:0]   store_data;
  logic [VW-1:0] vector_store_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_re;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata = 16'h0;
  logic [15:0]   data_from_memory;
  logic [VW-1:0] vector_data_from_memory;
  logic          stall;

  memory_access_unit #(.ADDR_W(AW), .LANES(LN)) dut (
    .clk(clk),
    .reset(reset),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .vector_op(vector_op),
    .address(address),
    .store_data(store_data),
    .vector_store_data(vector_store_data),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_re(mem_re),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .data_from_memory(data_from_memory),
    .vector_data_from_memory(vector_data_from_memory),
    .stall(stall)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  int cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0]   addr_q [$];
  logic [15:0]   wd_q [$];
  logic [15:0]   res_q [$];
  logic [15:0]   exp_dat;
  logic [VW-1:0] exp_vec;

  int ns, nr, nw, cf, cl, prev_cl;

  task automatic drive_idle();
    mem_read = 0;
    mem_write = 0;
    vector_op = 0;
    address = '0;
    store_data = '0;
    vector_store_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request and watches it until stall drops; returns at
  // the negedge of the completing cycle with inputs still applied.
  task automatic run_req(
    input  logic          rd,
    input  logic          wr,
    input  logic          vec,
    input  logic [15:0]   a,
    input  logic [15:0]   sd,
    input  logic [VW-1:0] vd,
    output int            nstall,
    output int            nrd,
    output int            nwr,
    output int            c_first,
    output int            c_last
  );
    logic [15:0] e;
    int n;
    mem_read = rd;
    mem_write = wr;
    vector_op = vec;
    address = a;
    store_data = sd;
    vector_store_data = vd;
    nstall = 0; nrd = 0; nwr = 0;
    c_first = -1; c_last = -1;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (mem_re || mem_we) begin
        if (c_first < 0) c_first = cyc;
        total_cnt++;
        if (addr_q.size() == 0) begin
          $display("FAIL strobe_addr: unexpected strobe at %h",
                   mem_addr);
        end else begin
          e = addr_q.pop_front();
          if (mem_addr !== e)
            $display("FAIL strobe_addr: got %h want %h", mem_addr, e);
          else pass_cnt++;
        end
        if (mem_re) nrd++;
        if (mem_we) begin
          nwr++;
          total_cnt++;
          if (wd_q.size() == 0) begin
            $display("FAIL wdata: unexpected write %h", mem_wdata);
          end else begin
            e = wd_q.pop_front();
            if (mem_wdata !== e)
              $display("FAIL wdata: got %h want %h", mem_wdata, e);
            else pass_cnt++;
          end
        end
      end
      if (stall === 1'b1) nstall++;
      else break;
      step();
    end
    c_last = cyc;
    if (n == 40) begin
      total_cnt++;
      $display("FAIL req_timeout: stall still %b after 40 cycles",
               stall);
    end
  endtask

  task automatic check_lanes(input string nm);
    logic [15:0] e;
    for (int k = 0; k < LN; k++) begin
      e = res_q.pop_front();
      total_cnt++;
      if (vector_data_from_memory[16*k +: 16] !== e)
        $display("FAIL %s lane%0d: got %h want %h", nm, k,
                 vector_data_from_memory[16*k +: 16], e);
      else pass_cnt++;
      exp_vec[16*k +: 16] = e;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total_cnt++;
    if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall);
    else pass_cnt++;
    total_cnt++;
    if (mem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", mem_we);
    else pass_cnt++;
    total_cnt++;
    if (mem_re !== 1'b0) $display("FAIL rst_re: got %b want 0", mem_re);
    else pass_cnt++;
    total_cnt++;
    if (mem_addr !== 16'h0)
      $display("FAIL rst_addr: got %h want 0", mem_addr);
    else pass_cnt++;
    total_cnt++;
    if (mem_wdata !== 16'h0)
      $display("FAIL rst_wdata: got %h want 0", mem_wdata);
    else pass_cnt++;
    total_cnt++;
    if (data_from_memory !== 16'h0)
      $display("FAIL rst_dfm: got %h want 0", data_from_memory);
    else pass_cnt++;
    total_cnt++;
    if (vector_data_from_memory !== '0)
      $display("FAIL rst_vdfm: got %h want 0", vector_data_from_memory);
    else pass_cnt++;
    reset = 0;
    step();
    exp_dat = '0;
    exp_vec = '0;
  endtask

  task automatic test_scalar_store();
    addr_q.push_back(16'h0010);
    wd_q.push_back(16'hBEEF);
    run_req(0, 1, 0, 16'h0010, 16'hBEEF, '0, ns, nr, nw, cf, cl);
    total_cnt++;
    if (ns !== 0) $display("FAIL sst_stall: got %0d want 0", ns);
    else pass_cnt++;
    total_cnt++;
    if (nw !== 1 || nr !== 0)
      $display("FAIL sst_strobes: got w%0d r%0d want w1 r0", nw, nr);
    else pass_cnt++;
    step();
    drive_idle();
    @(negedge clk);
    total_cnt++;
    if (mem_we !== 0 || mem_re !== 0 || stall !== 0)
      $display("FAIL idle_quiet: got we%b re%b st%b want 000",
               mem_we, mem_re, stall);
    else pass_cnt++;
    total_cnt++;
    if (mem[16'h0010] !== 16'hBEEF)
      $display("FAIL sst_mem: got %h want beef", mem[16'h0010]);
    else pass_cnt++;
    step();
  endtask

  task automatic test_scalar_load();
    mem[16'h0020] = 16'h1234;
    addr_q.push_back(16'h0020);
    res_q.push_back(16'h1234);
    run_req(1, 0, 0, 16'h0020, '0, '0, ns, nr, nw, cf, cl);
    total_cnt++;
    if (ns !== 2) $display("FAIL sld_stall: got %0d want 2", ns);
    else pass_cnt++;
    exp_dat = res_q.pop_front();
    total_cnt++;
    if (data_from_memory !== exp_dat)
      $display("FAIL sld_data: got %h want %h", data_from_memory, exp_dat);
    else pass_cnt++;
    total_cnt++;
    if (vector_data_from_memory !== exp_vec)
      $display("FAIL sld_vec_hold: got %h want %h",
               vector_data_from_memory, exp_vec);
    else pass_cnt++;
    step();
    drive_idle();
  endtask

  task automatic test_vector_load_wrap();
    logic [15:0] a;
    for (int k = 0; k < LN; k++) begin
      a = 16'hFFFC + 16'(k);
      mem[a] = 16'h00A0 + 16'(k);
      addr_q.push_back(a);
      res_q.push_back(16'h00A0 + 16'(k));
    end
    run_req(1, 0, 1, 16'hFFFC, '0, '0, ns, nr, nw, cf, cl);
    total_cnt++;
    if (ns !== 9) $display("FAIL vld_stall: got %0d want 9", ns);
    else pass_cnt++;
    total_cnt++;
    if (nr !== 8) $display("FAIL vld_reads: got %0d want 8", nr);
    else pass_cnt++;
    check_lanes("vld");
    total_cnt++;
    if (data_from_memory !== exp_dat)
      $display("FAIL vld_dat_hold: got %h want %h",
               data_from_memory, exp_dat);
    else pass_cnt++;
    step();
    drive_idle();
  endtask

  task automatic test_vector_store();
    logic [VW-1:0] vd;
    for (int k = 0; k < LN; k++) begin
      vd[16*k +: 16] = 16'h0100 + 16'(k);
      addr_q.push_back(16'h0040 + 16'(k));
      wd_q.push_back(16'h0100 + 16'(k));
    end
    run_req(0, 1, 1, 16'h0040, '0, vd, ns, nr, nw, cf, cl);
    total_cnt++;
    if (ns !== 7) $display("FAIL vst_stall: got %0d want 7", ns);
    else pass_cnt++;
    total_cnt++;
    if (nw !== 8 || nr !== 0)
      $display("FAIL vst_strobes: got w%0d r%0d want w8 r0", nw, nr);
    else pass_cnt++;
    total_cnt++;
    if (vector_data_from_memory !== exp_vec)
      $display("FAIL vst_vec_hold: got %h want %h",
               vector_data_from_memory, exp_vec);
    else pass_cnt++;
    step();
    for (int k = 0; k < LN; k++) begin
      addr_q.push_back(16'h0040 + 16'(k));
      res_q.push_back(16'h0100 + 16'(k));
    end
    run_req(1, 0, 1, 16'h0040, '0, '0, ns, nr, nw, cf, cl);
    check_lanes("vrb");
    step();
    drive_idle();
  endtask

  task automatic test_illegal_rw();
    mem[16'h0030] = 16'h5A5A;
    addr_q.push_back(16'h0030);
    res_q.push_back(16'h5A5A);
    run_req(1, 1, 0, 16'h0030, 16'hDEAD, '0, ns, nr, nw, cf, cl);
    total_cnt++;
    if (nw !== 0 || nr !== 1)
      $display("FAIL rw_strobes: got w%0d r%0d want w0 r1", nw, nr);
    else pass_cnt++;
    total_cnt++;
    if (ns !== 2) $display("FAIL rw_stall: got %0d want 2", ns);
    else pass_cnt++;
    exp_dat = res_q.pop_front();
    total_cnt++;
    if (data_from_memory !== exp_dat)
      $display("FAIL rw_data: got %h want %h", data_from_memory, exp_dat);
    else pass_cnt++;
    step();
    drive_idle();
    total_cnt++;
    if (mem[16'h0030] !== 16'h5A5A)
      $display("FAIL rw_mem: got %h want 5a5a", mem[16'h0030]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    mem[16'h0050] = 16'h7777;
    addr_q.push_back(16'h0050);
    res_q.push_back(16'h7777);
    for (int k = 0; k < LN; k++) begin
      mem[16'h0060 + 16'(k)] = 16'h00C0 + 16'(k);
    end
    run_req(1, 0, 0, 16'h0050, '0, '0, ns, nr, nw, cf, cl);
    exp_dat = res_q.pop_front();
    total_cnt++;
    if (data_from_memory !== exp_dat)
      $display("FAIL b2b_sdata: got %h want %h",
               data_from_memory, exp_dat);
    else pass_cnt++;
    prev_cl = cl;
    step();
    for (int k = 0; k < LN; k++) begin
      addr_q.push_back(16'h0060 + 16'(k));
      res_q.push_back(16'h00C0 + 16'(k));
    end
    run_req(1, 0, 1, 16'h0060, '0, '0, ns, nr, nw, cf, cl);
    total_cnt++;
    if (cf - prev_cl !== 1)
      $display("FAIL b2b_gap: got %0d want 1", cf - prev_cl);
    else pass_cnt++;
    total_cnt++;
    if (ns !== 9) $display("FAIL b2b_stall: got %0d want 9", ns);
    else pass_cnt++;
    check_lanes("b2b");
    total_cnt++;
    if (data_from_memory !== exp_dat)
      $display("FAIL b2b_dat_hold: got %h want %h",
               data_from_memory, exp_dat);
    else pass_cnt++;
    step();
    drive_idle();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < LN; k++) begin
      mem[16'h0080 + 16'(k)] = 16'h00E0 + 16'(k);
    end
    mem_read = 1;
    vector_op = 1;
    address = 16'h0080;
    @(negedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1 reset = 1;
    #1;
    total_cnt++;
    if (stall !== 0 || mem_re !== 0)
      $display("FAIL mrst_strobe: got st%b re%b want 00", stall, mem_re);
    else pass_cnt++;
    total_cnt++;
    if (dut.beat_q !== '0)
      $display("FAIL mrst_beat: got %0d want 0", dut.beat_q);
    else pass_cnt++;
    total_cnt++;
    if (data_from_memory !== 16'h0 || vector_data_from_memory !== '0)
      $display("FAIL mrst_res: got %h/%h want 0",
               data_from_memory, vector_data_from_memory);
    else pass_cnt++;
    exp_dat = '0;
    exp_vec = '0;
    drive_idle();
    @(negedge clk);
    reset = 0;
    step();
    addr_q.push_back(16'h0020);
    res_q.push_back(16'h1234);
    run_req(1, 0, 0, 16'h0020, '0, '0, ns, nr, nw, cf, cl);
    exp_dat = res_q.pop_front();
    total_cnt++;
    if (data_from_memory !== exp_dat || ns !== 2)
      $display("FAIL mrst_after: got %h st%0d want %h st2",
               data_from_memory, ns, exp_dat);
    else pass_cnt++;
    total_cnt++;
    if (vector_data_from_memory !== exp_vec)
      $display("FAIL mrst_vec: got %h want %h",
               vector_data_from_memory, exp_vec);
    else pass_cnt++;
    step();
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1;
    drive_idle();
    repeat (3) @(posedge clk);
    test_reset();
    test_scalar_store();
    test_scalar_load();
    test_vector_load_wrap();
    test_vector_store();
    test_illegal_rw();
    test_back_to_back();
    test_reset_mid();
    total_cnt++;
    if (addr_q.size() != 0 || wd_q.size() != 0)
      $display("FAIL sb_drain: got %0d/%0d left want 0/0",
               addr_q.size(), wd_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Memory stage of the CPU pipeline, sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. It executes scalar (16-bit) and vector (128-bit, 8 × 16-bit lanes) loads and stores over a single 16-bit synchronous data-memory port. It sequences multi-beat vector transfers with an FSM and stalls upstream stages until results are ready. It produces `data_from_memory` and `vector_data_from_memory` for the MEM/WB register.

## Interface
Parameters:
- `ADDR_W`, default 16: word address width; addresses are 16-bit-word granular.
- `LANES`, default 8: 16-bit lanes per vector; the vector is `16*LANES` bits.

Ports:
- `clk`  in  1  clock; the already-decided clock.
- `reset`  in  1  reset; the already-decided reset, asynchronous, active-high.
- `mem_read`  in  1  load request from EX/MEM.
- `mem_write`  in  1  store request from EX/MEM.
- `vector_op`  in  1  1 selects a vector transfer, 0 a scalar transfer.
- `address`  in  ADDR_W  base word address.
- `store_data`  in  16  scalar store data.
- `vector_store_data`  in  16*LANES  vector store data; lane k is bits [16k+15:16k].
- `mem_addr`  out  ADDR_W  memory port address.
- `mem_we`  out  1  memory write strobe.
- `mem_re`  out  1  memory read strobe.
- `mem_wdata`  out  16  memory write data.
- `mem_rdata`  in  16  read data, valid the cycle after the `mem_re` address is presented.
- `data_from_memory`  out  16  last scalar load result.
- `vector_data_from_memory`  out  16*LANES  last vector load result.
- `stall`  out  1  freezes the PC, IF/ID, ID/EX and EX/MEM registers, and inserts a bubble into MEM/WB.

## Operation
- FSM states: IDLE, S_RD, V_RD, V_WR, DONE. Beat counter `beat` is 0..LANES.
- Upstream holds all inputs stable while `stall`=1.
- In IDLE, requests decode as follows:
  - `mem_read`=`mem_write`=1 is illegal. Read wins and the write is ignored.
  - Scalar store: `mem_we`=1, `mem_addr`=`address`, `mem_wdata`=`store_data` in the same cycle. `stall`=0 and the FSM stays in IDLE.
  - Scalar load: `mem_re`=1, `mem_addr`=`address`, `stall`=1, next state S_RD.
  - Vector load: `mem_re`=1, `mem_addr`=`address`, `stall`=1, `beat`←1, next state V_RD.
  - Vector store: write lane 0 to `address`, `stall`=1, `beat`←1, next state V_WR.
- S_RD: capture `mem_rdata` into `data_from_memory`. `stall`=1, next state DONE.
- V_RD:
  - Every cycle, capture `mem_rdata` into lane `beat`-1.
  - While `beat`<LANES, also issue a read of `address`+`beat` and increment `beat`.
  - When `beat`=LANES, the final lane is captured with no read issued, and the next state is DONE. `stall`=1 throughout.
- V_WR:
  - Write lane `beat` to `address`+`beat`.
  - `stall`=1 while `beat`<LANES-1.
  - On the last beat `stall`=0 and the next state is IDLE.
- DONE: `stall`=0, outputs hold, next state IDLE. The held instruction leaves the stage at the end of this cycle and is never re-accepted.
- Address arithmetic is modulo 2^ADDR_W; 0xFFFF+1 wraps to 0x0000.
- Load result registers change only on loads. Stores never disturb them.
- A scalar load leaves `vector_data_from_memory` unchanged, and a vector load leaves `data_from_memory` unchanged.
- With no request in IDLE, `mem_we`=`mem_re`=0 and `stall`=0.

## Timing
- Reset values: state IDLE, `beat`=0, `stall`=0, `mem_we`=0, `mem_re`=0, `mem_addr`=0, `mem_wdata`=0, `data_from_memory`=0, `vector_data_from_memory`=0.
- Reset is asynchronous and takes effect immediately, including mid-transfer. A partially written vector is left as-is, and no further strobes are issued.
- Memory strobes, address and write data are combinational from the state and inputs. Result registers update on posedge.
- Latencies, with cycle 0 being the first IDLE cycle that sees the request:
  - Scalar store: 1 cycle, `stall` never asserted.
  - Scalar load: `stall`=1 in cycles 0–1; DONE in cycle 2 with the result valid.
  - Vector load: reads in cycles 0–7 (LANES=8) and the last capture in cycle 8. `stall`=1 in cycles 0–8; DONE in cycle 9 with all lanes valid.
  - Vector store: writes in cycles 0–7. `stall`=1 in cycles 0–6 and 0 in cycle 7.
- Back-to-back operation: after DONE, or after the last V_WR beat, the next request is decoded in the following cycle with no extra bubble.

## Structure
- Shared package `cpu_pkg` holds:
  - `mem_state_t`, the enum {IDLE, S_RD, V_RD, V_WR, DONE};
  - `VEC_LANES` = 8;
  - `WORD_W` = 16.
- No sub-module is needed: a single module with one `always_ff` for the state, counter and result registers, and one `always_comb` for the port and `stall` decode.

## Test plan
- Reset, then scalar store of 0xBEEF to 0x0010 → `mem_we`=1, `mem_addr`=0x0010, `mem_wdata`=0xBEEF in the same cycle, `stall` never rises.
- Memory model preloaded with 0x1234 at 0x0020; scalar load → `stall`=1 for 2 cycles, then `data_from_memory`=0x1234 in the DONE cycle.
- Vector load from 0xFFFC with words 0xA0..0xA7 at 0xFFFC..0x0003 → addresses wrap 0xFFFF→0x0000, `stall`=1 for 9 cycles, and lane k = 0xA0+k.
- Vector store of lanes 0x0100+k to base 0x0040 → 8 writes to 0x0040..0x0047 with `stall` high for the first 7; a readback via vector load matches.
- `mem_read`=`mem_write`=1 scalar → treated as a load with no write strobe. Back-to-back scalar load then vector load → no extra bubble between DONE and the next request.
- Assert `reset` during beat 4 of a vector load → `stall`, `mem_re` and `beat` go to 0 immediately, the result registers read 0, and the next request executes normally.
